// File: rtl/aes_mix_columns_serial_pkg.sv
// Shared GF(2^8) definitions for the AES units (SubBytes, MixColumns, key schedule).
// Provides the byte/column types, the reduction polynomial, xtime and the matrix coefficients.
package aes_mix_columns_serial_pkg;

  localparam int AES_BYTE_W = 8;

  typedef logic [AES_BYTE_W-1:0]       aes_byte_t;
  typedef logic [3:0][AES_BYTE_W-1:0]  aes_col_t;

  localparam aes_byte_t AES_POLY = 8'h1B;

  // Element [0] holds the coefficient on the diagonal; each row uses these rotated right by its row index.
  localparam aes_col_t AES_FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
  localparam aes_col_t AES_INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[AES_BYTE_W-2:0], 1'b0} ^ (b[AES_BYTE_W-1] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a constant as an XOR of chained xtime terms; folds to fixed logic for constant c.
  function automatic aes_byte_t gf_mul(input aes_byte_t b, input aes_byte_t c);
    aes_byte_t acc;
    aes_byte_t p;
    acc = '0;
    p   = b;
    for (int i = 0; i < AES_BYTE_W; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_mix_column_comb.sv
// Purely combinational AES column mixer: 4 bytes in, 4 bytes out.
// Optional AES_MIX_COLUMNS_INVERSE_EN adds inverse_i selecting InvMixColumns.
module aes_mix_column_comb
  import aes_mix_columns_serial_pkg::*;
(
`ifdef AES_MIX_COLUMNS_INVERSE_EN
  input  logic     inverse_i,
`endif
  input  aes_col_t col_i,
  output aes_col_t col_o
);

  aes_col_t coef;

  always_comb begin
    coef = AES_FWD_COEF;
`ifdef AES_MIX_COLUMNS_INVERSE_EN
    if (inverse_i) coef = AES_INV_COEF;
`endif
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        col_o[r] = col_o[r] ^ gf_mul(col_i[j], coef[2'(j - r + 4)]);
      end
    end
  end

endmodule

// File: rtl/aes_mix_columns_serial.sv
// Byte-serial AES MixColumns Versat unit with a fixed 4-cycle latency (counter, buffers, output mux).
// Optional AES_MIX_COLUMNS_INVERSE_EN adds the inverse port for InvMixColumns.
module aes_mix_columns_serial
  import aes_mix_columns_serial_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              running,
`ifdef AES_MIX_COLUMNS_INVERSE_EN
  input  logic              inverse,
`endif
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0
);

  logic [1:0]            cnt_q, cnt_d;
  logic [2:0][7:0]       col_in_q, col_in_d;
  aes_col_t              col_out_q, col_out_d;
  aes_col_t              mixed;
  aes_byte_t             in_byte;
  logic                  unused_in_hi;

  assign in_byte      = in0[7:0];
  assign unused_in_hi = ^in0;

  // The fourth byte feeds the mixer directly so the column completes on its own consuming edge.
  aes_mix_column_comb u_mix (
`ifdef AES_MIX_COLUMNS_INVERSE_EN
    .inverse_i (inverse),
`endif
    .col_i     ({in_byte, col_in_q[2], col_in_q[1], col_in_q[0]}),
    .col_o     (mixed)
  );

  always_comb begin
    cnt_d     = cnt_q;
    col_in_d  = col_in_q;
    col_out_d = col_out_q;
    if (run) begin
      cnt_d     = '0;
      col_in_d  = '0;
      col_out_d = '0;
    end else if (running) begin
      case (cnt_q)
        2'd0:    col_in_d[0] = in_byte;
        2'd1:    col_in_d[1] = in_byte;
        2'd2:    col_in_d[2] = in_byte;
        default: col_out_d   = mixed;
      endcase
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      col_in_q  <= '0;
      col_out_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      col_in_q  <= col_in_d;
      col_out_q <= col_out_d;
    end
  end

  // Registered mux only: no combinational path from in0 to out0.
  assign out0 = DATA_W'(col_out_q[cnt_q]);

endmodule

// File: tb/tb_aes_mix_columns_serial.sv
// Directed self-checking bench for aes_mix_columns_serial using FIPS-197 MixColumns vectors.
module tb_aes_mix_columns_serial;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              run = 1'b0;
  logic              running = 1'b0;
`ifdef AES_MIX_COLUMNS_INVERSE_EN
  logic              inverse = 1'b0;
`endif
  logic [DATA_W-1:0] in0 = '0;
  logic [DATA_W-1:0] out0;

  int compared   = 0;
  int mismatched = 0;

  aes_mix_columns_serial #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .running (running),
`ifdef AES_MIX_COLUMNS_INVERSE_EN
    .inverse (inverse),
`endif
    .in0     (in0),
    .out0    (out0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] expected);
    compared++;
    assert (out0 === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, out0, expected);
    end
  endtask

  // Present one byte with running=1 for one edge, then check out0 in the following cycle.
  task automatic feed(input string tag, input logic [DATA_W-1:0] din,
                      input logic [DATA_W-1:0] expected);
    running = 1'b1;
    in0     = din;
    tick();
    check(tag, expected);
  endtask

  task automatic stall(input string tag, input logic [DATA_W-1:0] expected);
    running = 1'b0;
    in0     = 32'h0000_0077;
    tick();
    check(tag, expected);
  endtask

  initial begin
    #1;
    rst = 1'b1; running = 1'b1; in0 = 32'h0000_00aa;
    tick();
    check("reset", 32'h0);
    rst = 1'b0; run = 1'b1;
    tick();
    check("run_clear", 32'h0);
    run = 1'b0;

    // First column: zeros until the fourth byte is consumed.
    feed("c0_b0", 32'hdb, 32'h00);
    feed("c0_b1", 32'h13, 32'h00);
    feed("c0_b2", 32'h53, 32'h00);
    feed("c0_b3", 32'h45, 32'h8e);

    // c6 column with a 3-cycle stall between bytes 1 and 2; out0 must hold a1.
    feed("c1_b0", 32'hc6, 32'h4d);
    feed("c1_b1", 32'hc6, 32'ha1);
    stall("stall0", 32'ha1);
    stall("stall1", 32'ha1);
    stall("stall2", 32'ha1);
    feed("c1_b2", 32'hc6, 32'hbc);
    feed("c1_b3", 32'hc6, 32'hc6);

    // Back-to-back columns with no bubbles.
    feed("c2_b0", 32'hf2, 32'hc6);
    feed("c2_b1", 32'h0a, 32'hc6);
    feed("c2_b2", 32'h22, 32'hc6);
    feed("c2_b3", 32'h5c, 32'h9f);
    feed("c3_b0", 32'h01, 32'hdc);
    feed("c3_b1", 32'h01, 32'h58);
    feed("c3_b2", 32'h01, 32'h9d);
    feed("c3_b3", 32'h01, 32'h01);

    // Mid-column reset with running=1: byte 5d is dropped, outputs clear.
    feed("c4_b0", 32'hd4, 32'h01);
    feed("c4_b1", 32'hbf, 32'h01);
    rst = 1'b1;
    feed("mid_rst", 32'h5d, 32'h00);
    rst = 1'b0;

    // Upper input bits ignored, upper output bits zero.
    feed("c5_b0", 32'hffff_ffd4, 32'h00);
    feed("c5_b1", 32'hffff_ffbf, 32'h00);
    feed("c5_b2", 32'hffff_ff5d, 32'h00);
    feed("c5_b3", 32'hffff_ff30, 32'h04);

    // Mid-column run pulse with running=1: byte 53 dropped, column restarts.
    feed("c6_b0", 32'hdb, 32'h66);
    feed("c6_b1", 32'h13, 32'h81);
    run = 1'b1;
    feed("mid_run", 32'h53, 32'h00);
    run = 1'b0;

    feed("c7_b0", 32'hffff_ffdb, 32'h00);
    feed("c7_b1", 32'hffff_ff13, 32'h00);
    feed("c7_b2", 32'hffff_ff53, 32'h00);
    feed("c7_b3", 32'hffff_ff45, 32'h8e);
    feed("c8_b0", 32'h00, 32'h4d);
    feed("c8_b1", 32'h00, 32'ha1);
    feed("c8_b2", 32'h00, 32'hbc);
    feed("c8_b3", 32'h00, 32'h00);

`ifdef AES_MIX_COLUMNS_INVERSE_EN
    // Inverse only matters on the cnt==3 edge; toggles elsewhere are ignored.
    run = 1'b1;
    tick();
    run = 1'b0;
    inverse = 1'b0;
    feed("inv_b0", 32'h8e, 32'h00);
    inverse = 1'b1;
    feed("inv_b1", 32'h4d, 32'h00);
    inverse = 1'b0;
    feed("inv_b2", 32'ha1, 32'h00);
    inverse = 1'b1;
    feed("inv_b3", 32'hbc, 32'hdb);
    inverse = 1'b0;
    feed("inv_o1", 32'h00, 32'h13);
    inverse = 1'b1;
    feed("inv_o2", 32'h00, 32'h53);
    inverse = 1'b0;
    feed("inv_o3", 32'h00, 32'h45);
`endif

    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aes_mix_columns_serial.md
Name: aes_mix_columns_serial

Overview:
- Versat functional unit directly downstream of the AES SubBytes unit. It consumes the SubBytes byte stream one byte per cycle, column-major: byte 0 of column 0, byte 1 of column 0, and so on.
- It buffers each 4-byte column, applies AES MixColumns over GF(2^8) with polynomial 0x11B, and emits the mixed column serially, one byte per cycle.
- Output latency is a fixed 4 cycles, so the Versat scheduler can place the unit statically.

Parameters:
- DATA_W, default 32: datapath width of in0/out0. Must be >= 8. Only bits [7:0] carry data.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  one-cycle pulse that starts a new accelerator run and restarts column alignment.
- running  input  1  high while the accelerator runs; each high cycle consumes one input byte.
- in0  input  DATA_W  in0[7:0] is the SubBytes output byte; upper bits are ignored.
- out0  output  DATA_W  out0[7:0] is the mixed byte; out0[DATA_W-1:8] is always 0. Declared versat_latency=4.

Behaviour:
- State:
  - cnt[1:0]: byte position within the column.
  - col_in[0..2]: partial input column, 8 bits each.
  - col_out[0..3]: completed mixed column, 8 bits each.
- Reset (rst=1 at an edge):
  - cnt, col_in and col_out are cleared to 0, so out0 reads 0 from the next cycle.
  - rst has priority over run and running.
  - A reset in mid-column discards the partial column.
- run=1 (rst=0):
  - Clears cnt, col_in and col_out to 0.
  - The in0 byte in that cycle is not consumed, even if running=1. run has priority over running.
- running=1 (rst=0, run=0):
  - If cnt<3: col_in[cnt] <= in0[7:0].
  - If cnt==3: col_out <= MixColumns(col_in[0], col_in[1], col_in[2], in0[7:0]). This happens on the same edge, with no extra bubble.
  - cnt <= cnt+1, wrapping 3 to 0.
- running=0: all state holds and out0 holds. A stall of any length is transparent to the 4-cycle latency.
- Output: out0[7:0] = col_out[cnt], a mux of registers with no combinational path from in0.
- Timing:
  - Input byte j of a column is accepted in running cycle t0+j.
  - Mixed byte j appears in running cycle t0+4+j.
  - Before the first column completes, out0 = 0.
  - Output of column c and input of column c+1 overlap, giving full throughput.
- Arithmetic:
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 8'h00).
  - Forward matrix rows, with all sums as XOR:
    - r0 = 2a0 ^ 3a1 ^ a2 ^ a3
    - r1 = a0 ^ 2a1 ^ 3a2 ^ a3
    - r2 = a0 ^ a1 ^ 2a2 ^ 3a3
    - r3 = 3a0 ^ a1 ^ a2 ^ 2a3

Optional Feature:
- Macro: AES_MIX_COLUMNS_INVERSE_EN.
- When defined:
  - Adds input port inverse (1 bit), sampled on the cnt==3 consuming edge.
  - inverse=1 selects InvMixColumns: rows {0e,0b,0d,09} rotated per row, built from chained xtime.
  - inverse=0 selects forward MixColumns.
  - The latency of 4 is unchanged.
- When not defined: the port is absent and only the forward transform exists. No inverse logic is synthesized.

Decomposition:
- Shared include aes_gf_defs:
  - xtime function.
  - AES_POLY = 8'h1B.
  - Forward coefficients {02,03,01,01} and inverse coefficients {0e,0b,0d,09}.
  - Byte type width AES_BYTE_W = 8.
- SubBytes and the future key-schedule unit share the same include.
- One natural sub-module, aes_mix_column_comb: purely combinational 4-byte-in, 4-byte-out column mixer, with an inverse input under the macro.
- This top owns only the counter, buffers and output mux.

Test Plan:
- rst, then run, then running=1 with in0 = db,13,53,45 → out0 = 00000000 for 4 cycles, then 8e,4d,a1,bc.
- Back-to-back columns db,13,53,45,f2,0a,22,5c,01,01,01,01 → from cycle 4: 8e,4d,a1,bc,9f,dc,58,9d,01,01,01,01, with no bubbles.
- Stall: running=0 for 3 cycles between input bytes 1 and 2 of column c6,c6,c6,c6 → out0 holds during the stall; the column then emits c6 ×4, 4 running cycles after its first byte.
- Mid-column disturbance: feed d4,bf then assert rst (or run) with running=1 → out0=0 next cycle and cnt=0; the byte in the rst/run cycle is dropped. The next column d4,bf,5d,30 → 04,66,81,e5.
- Upper bits: in0 = FFFFFFdb,..,FFFFFF45 → same 8e,4d,a1,bc with out0[31:8] = 0.
- With AES_MIX_COLUMNS_INVERSE_EN, inverse=1, in0 = 8e,4d,a1,bc → db,13,53,45. Toggling inverse on non-consuming cycles has no effect.
